// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake body tracker.
//   COORD_W      coordinate width of every body slot
//   EMPTY_COORD  value held by unused slots (and by x-1 / y-1 from 0)
//   dir_t        movement direction encoding
//   state_t      body tracker FSM states
//   coord_t      one (x,y) tile coordinate
package snake_pkg;

  localparam int COORD_W = 32;
  localparam logic [COORD_W-1:0] EMPTY_COORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,  // y-1
    DIR_RIGHT = 2'd1,  // x+1
    DIR_DOWN  = 2'd2,  // y+1
    DIR_LEFT  = 2'd3   // x-1
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SCAN,
    ST_COMMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ DIR_DOWN);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// snake_next_head: combinational one-tile step of the head coordinate.
//   head       current head (slot 0)
//   dir        direction to move in
//   next       head position after the move
//   in_bounds  next lies on the playfield
// Build option SNAKE_WRAP_EN: leaving one edge re-enters at the opposite
// edge and in_bounds is always 1; without it a wall hit is reported.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10
) (
  input  coord_t head,
  input  dir_t   dir,
  output coord_t next,
  output logic   in_bounds
);

  localparam logic [COORD_W-1:0] GW  = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GH  = COORD_W'(GRID_H);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  coord_t raw;

  always_comb begin
    raw = head;
    unique case (dir)
      DIR_UP:    raw.y = head.y - ONE;
      DIR_RIGHT: raw.x = head.x + ONE;
      DIR_DOWN:  raw.y = head.y + ONE;
      DIR_LEFT:  raw.x = head.x - ONE;
    endcase
  end

  always_comb begin
    next = raw;
`ifdef SNAKE_WRAP_EN
    // Stepping off 0 underflows to all-ones; stepping off the far edge lands on GRID_W/H.
    if (raw.x == EMPTY_COORD) next.x = GW - ONE;
    else if (raw.x == GW)     next.x = '0;
    if (raw.y == EMPTY_COORD) next.y = GH - ONE;
    else if (raw.y == GH)     next.y = '0;
    in_bounds = 1'b1;
`else
    // Unsigned compare also rejects the all-ones underflow from 0.
    in_bounds = (raw.x < GW) && (raw.y < GH);
`endif
  end

endmodule

// File: rtl/snake_body_tracker.sv
// snake_body_tracker: authoritative snake body state for the renderer.
//   clk, reset      clock, async active-high reset
//   restart         sync re-initialise, overrides everything else
//   step            advance one tile (taken only while ready)
//   dir             requested direction (0 up, 1 right, 2 down, 3 left)
//   grow            lengthen by one at the next committed move
//   ready           FSM idle, a step will be accepted
//   x_values        slot i at [32i+:32], slot 0 = head, unused = all-ones
//   y_values        same layout as x_values
//   length          number of valid slots
//   game_done       sticky collision flag
//   moved           one-cycle pulse per committed move
// Build option SNAKE_WRAP_EN (in snake_next_head): playfield wraps, only
// self-collision ends the game.
// Flow: IDLE -> CHECK (wall) -> SCAN (one body slot per cycle) -> COMMIT.
// The body shift happens on the edge into COMMIT, so moved and the new
// arrays become visible together; ready returns one cycle later.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int MAX_SEGMENTS = 100,
  parameter int GRID_W       = 10,
  parameter int GRID_H       = 10,
  parameter int START_X      = 2,
  parameter int START_Y      = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              restart,
  input  logic                              step,
  input  logic [1:0]                        dir,
  input  logic                              grow,
  output logic                              ready,
  output logic [COORD_W*MAX_SEGMENTS-1:0]   x_values,
  output logic [COORD_W*MAX_SEGMENTS-1:0]   y_values,
  output logic [7:0]                        length,
  output logic                              game_done,
  output logic                              moved
);

  localparam int IDX_W = $clog2(MAX_SEGMENTS);
  localparam logic [7:0] MAX_LEN = 8'(MAX_SEGMENTS);

  typedef logic [MAX_SEGMENTS-1:0][COORD_W-1:0] slots_t;

  function automatic slots_t init_slots(input logic [COORD_W-1:0] head_v);
    slots_t s;
    for (int i = 0; i < MAX_SEGMENTS; i++) s[i] = EMPTY_COORD;
    s[0] = head_v;
    return s;
  endfunction

  localparam slots_t INIT_X = init_slots(COORD_W'(START_X));
  localparam slots_t INIT_Y = init_slots(COORD_W'(START_Y));

  slots_t            xs, ys, nx_x, nx_y;
  state_t            state;
  dir_t              cur_dir, new_dir;
  logic              grow_pending;
  coord_t            head_cur, nh, nh_calc;
  logic              nh_in, nh_in_calc;
  logic [IDX_W-1:0]  k;
  logic [7:0]        scan_lim, new_len;
  logic              hit, scan_last, do_commit;

  assign x_values = xs;
  assign y_values = ys;

  // A reversal straight into the neck is ignored once there is a neck.
  always_comb begin
    new_dir = dir_t'(dir);
    if (dir_t'(dir) == dir_opposite(cur_dir) && length > 8'd1) new_dir = cur_dir;
  end

  assign head_cur.x = xs[0];
  assign head_cur.y = ys[0];

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .head      (head_cur),
    .dir       (new_dir),
    .next      (nh_calc),
    .in_bounds (nh_in_calc)
  );

  // Without growth the tail vacates this move, so it is not an obstacle.
  assign scan_lim  = grow_pending ? length : length - 8'd1;
  assign new_len   = length + ((grow_pending && length < MAX_LEN) ? 8'd1 : 8'd0);
  assign hit       = (xs[k] == nh.x) && (ys[k] == nh.y);
  assign scan_last = (8'(k) == scan_lim - 8'd1);
  assign do_commit = (state == ST_CHECK && nh_in && scan_lim == 8'd0) ||
                     (state == ST_SCAN && !hit && scan_last);

  // Shifted body image; slots at or past the new length go empty,
  // which is also how the old tail is dropped.
  for (genvar i = 0; i < MAX_SEGMENTS; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign nx_x[0] = nh.x;
      assign nx_y[0] = nh.y;
    end else begin : g_body
      assign nx_x[i] = (8'(i) < new_len) ? xs[i-1] : EMPTY_COORD;
      assign nx_y[i] = (8'(i) < new_len) ? ys[i-1] : EMPTY_COORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs <= INIT_X;
      ys <= INIT_Y;
    end else if (restart) begin
      xs <= INIT_X;
      ys <= INIT_Y;
    end else if (do_commit) begin
      xs <= nx_x;
      ys <= nx_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      length       <= 8'd1;
      cur_dir      <= DIR_RIGHT;
      grow_pending <= 1'b0;
      game_done    <= 1'b0;
      moved        <= 1'b0;
      nh           <= '0;
      nh_in        <= 1'b0;
      k            <= '0;
    end else if (restart) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      length       <= 8'd1;
      cur_dir      <= DIR_RIGHT;
      grow_pending <= 1'b0;
      game_done    <= 1'b0;
      moved        <= 1'b0;
      nh           <= '0;
      nh_in        <= 1'b0;
      k            <= '0;
    end else begin
      moved <= 1'b0;
      if (grow) grow_pending <= 1'b1;
      unique case (state)
        ST_IDLE: if (step) begin
          cur_dir <= new_dir;
          nh      <= nh_calc;
          nh_in   <= nh_in_calc;
          ready   <= 1'b0;
          state   <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!nh_in) begin
            state     <= ST_DONE;
            game_done <= 1'b1;
          end else if (scan_lim != 8'd0) begin
            k     <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            state     <= ST_DONE;
            game_done <= 1'b1;
          end else if (!scan_last) begin
            k <= k + 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: ;  // ST_DONE holds until reset/restart
      endcase
      // A grow sampled on the commit edge belongs to the next move.
      if (do_commit) begin
        state        <= ST_COMMIT;
        moved        <= 1'b1;
        length       <= new_len;
        grow_pending <= grow;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
module tb_snake_body_tracker;
  localparam int TMAX = 16;
  localparam int GW = 10, GH = 10, SX = 2, SY = 5;
  localparam int VW = 32 * TMAX;

  logic clk = 1'b0, reset = 1'b0, restart = 1'b0, step = 1'b0, grow = 1'b0;
  logic [1:0] dir = 2'd0;
  logic ready, game_done, moved;
  logic [VW-1:0] x_values, y_values;
  logic [7:0] length;

  int checks = 0, failures = 0;

  // Reference model: body as coordinate queues, head first.
  int qx[$], qy[$];
  int m_dir;
  bit m_gp;

  snake_body_tracker #(
    .MAX_SEGMENTS(TMAX), .GRID_W(GW), .GRID_H(GH), .START_X(SX), .START_Y(SY)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .step(step), .dir(dir),
    .grow(grow), .ready(ready), .x_values(x_values), .y_values(y_values),
    .length(length), .game_done(game_done), .moved(moved)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] pack_q(input bit is_y);
    logic [VW-1:0] v;
    for (int i = 0; i < TMAX; i++) begin
      if (i < qx.size()) v[32*i +: 32] = is_y ? 32'(qy[i]) : 32'(qx[i]);
      else               v[32*i +: 32] = 32'hFFFF_FFFF;
    end
    return v;
  endfunction

  task automatic model_reset();
    qx = {SX};
    qy = {SY};
    m_dir = 1;
    m_gp = 1'b0;
  endtask

  // One move: predict outcome from the rules, drive it, compare.
  task automatic do_step(input int d, input bit g, input bit noise,
                         input bit late_grow, output bit done_o);
    logic [VW-1:0] pre_x, pre_y, exp_x, exp_y;
    int nd, hx, hy, lim, hitm, exp_cyc, cyc;
    bit out, exp_done, seen, stable, grew;
    pre_x = pack_q(0);
    pre_y = pack_q(1);
    m_gp = m_gp | g;
    nd = (d == (m_dir ^ 2) && qx.size() > 1) ? m_dir : d;
    m_dir = nd;
    hx = qx[0] + ((nd == 1) ? 1 : 0) - ((nd == 3) ? 1 : 0);
    hy = qy[0] + ((nd == 2) ? 1 : 0) - ((nd == 0) ? 1 : 0);
`ifdef SNAKE_WRAP_EN
    if (hx < 0) hx = GW - 1; else if (hx >= GW) hx = 0;
    if (hy < 0) hy = GH - 1; else if (hy >= GH) hy = 0;
    out = 1'b0;
`else
    out = (hx < 0) || (hx >= GW) || (hy < 0) || (hy >= GH);
`endif
    exp_done = 1'b0;
    if (out) begin
      exp_done = 1'b1;
      exp_cyc = 2;
    end else begin
      lim = m_gp ? qx.size() : qx.size() - 1;
      hitm = -1;
      for (int m = 0; m < lim; m++)
        if (hitm < 0 && qx[m] == hx && qy[m] == hy) hitm = m;
      if (hitm >= 0) begin
        exp_done = 1'b1;
        exp_cyc = 3 + hitm;
      end else begin
        exp_cyc = 2 + lim;
        grew = m_gp && (qx.size() < TMAX);
        qx.push_front(hx);
        qy.push_front(hy);
        if (!grew) begin
          void'(qx.pop_back());
          void'(qy.pop_back());
        end
        m_gp = 1'b0;
      end
    end
    exp_x = pack_q(0);
    exp_y = pack_q(1);

    dir = 2'(d); step = 1'b1; grow = g;
    @(negedge clk);
    step = 1'b0; grow = 1'b0;
    cyc = 1; seen = 1'b0; stable = 1'b1;
    while (!seen && cyc < TMAX + 8) begin
      if (moved || game_done) seen = 1'b1;
      else begin
        if (x_values !== pre_x || y_values !== pre_y) stable = 1'b0;
        if (noise) step = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
    end
    step = 1'b0;

    checks++;
    if (!seen || game_done !== exp_done || cyc != exp_cyc) begin
      failures++;
      $display("FAIL step_outcome dir=%0d: seen=%0b done=%b cyc=%0d, want done=%0b cyc=%0d",
               d, seen, game_done, cyc, exp_done, exp_cyc);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL step_stable dir=%0d: arrays changed before commit, want unchanged", d);
    end
    checks++;
    if (x_values !== exp_x) begin
      failures++;
      $display("FAIL step_x got=%h want=%h", x_values, exp_x);
    end
    checks++;
    if (y_values !== exp_y) begin
      failures++;
      $display("FAIL step_y got=%h want=%h", y_values, exp_y);
    end
    checks++;
    if (length !== 8'(qx.size()) || ready !== 1'b0) begin
      failures++;
      $display("FAIL step_len_ready got len=%0d ready=%b want len=%0d ready=0",
               length, ready, qx.size());
    end
    if (!exp_done) begin
      if (late_grow) begin grow = 1'b1; m_gp = 1'b1; end
      @(negedge clk);
      grow = 1'b0;
      checks++;
      if (ready !== 1'b1 || moved !== 1'b0) begin
        failures++;
        $display("FAIL step_return got ready=%b moved=%b want ready=1 moved=0", ready, moved);
      end
    end
    done_o = exp_done;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    checks++;
    if (x_values !== pack_q(0) || y_values !== pack_q(1) || length !== 8'd1 ||
        ready !== 1'b1 || game_done !== 1'b0 || moved !== 1'b0) begin
      failures++;
      $display("FAIL restart got head=(%0d,%0d) len=%0d ready=%b done=%b moved=%b want (%0d,%0d) 1 1 0 0",
               x_values[31:0], y_values[31:0], length, ready, game_done, moved, SX, SY);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if (x_values[31:0] !== 32'(SX) || y_values[31:0] !== 32'(SY)) begin
      failures++;
      $display("FAIL reset_head got (%0d,%0d) want (%0d,%0d)",
               x_values[31:0], y_values[31:0], SX, SY);
    end
    checks++;
    if (x_values !== pack_q(0) || y_values !== pack_q(1)) begin
      failures++;
      $display("FAIL reset_slots got x=%h want x=%h", x_values, pack_q(0));
    end
    checks++;
    if (length !== 8'd1 || ready !== 1'b1 || game_done !== 1'b0 || moved !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got len=%0d ready=%b done=%b moved=%b want 1 1 0 0",
               length, ready, game_done, moved);
    end
  endtask

  task automatic test_basic_move();
    bit dn;
    do_step(1, 0, 0, 0, dn);
  endtask

  task automatic test_grow_reversal();
    bit dn;
    grow = 1'b1; m_gp = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    do_step(1, 0, 0, 0, dn);  // (4,5) length 2
    do_step(3, 0, 0, 0, dn);  // reversal ignored -> (5,5)
  endtask

  task automatic test_wall();
    bit dn;
    logic [VW-1:0] fx;
    bit quiet;
    do_restart();
    dn = 1'b0;
    for (int i = 0; i < 8 && !dn; i++) do_step(1, 0, 0, 0, dn);
    if (dn) begin
      fx = x_values;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      quiet = 1'b1;
      repeat (3) begin
        if (moved !== 1'b0 || x_values !== fx || game_done !== 1'b1 || ready !== 1'b0) quiet = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (!quiet) begin
        failures++;
        $display("FAIL done_frozen got moved/array change/done=%b ready=%b, want frozen done=1 ready=0",
                 game_done, ready);
      end
    end
  endtask

  task automatic test_self_collision();
    bit dn;
    do_restart();
    do_step(1, 1, 0, 0, dn);
    do_step(1, 1, 0, 0, dn);
    do_step(1, 1, 0, 0, dn);
    do_step(2, 1, 0, 0, dn);
    do_step(3, 0, 0, 0, dn);
    do_step(0, 0, 0, 0, dn);  // into slot 3
  endtask

  task automatic test_tail_follow();
    bit dn;
    do_restart();
    do_step(1, 1, 0, 0, dn);
    do_step(2, 1, 0, 0, dn);
    do_step(3, 1, 0, 0, dn);
    do_step(0, 0, 0, 0, dn);  // into vacating tail
  endtask

  task automatic test_restart_mid_scan();
    bit dn;
    do_restart();
    do_step(1, 1, 0, 0, dn);
    do_step(1, 1, 0, 0, dn);
    dir = 2'd1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || moved !== 1'b0) begin
      failures++;
      $display("FAIL mid_scan_busy got ready=%b moved=%b want 0 0", ready, moved);
    end
    do_restart();
  endtask

  task automatic test_max_length();
    bit dn;
    do_restart();
    for (int i = 0; i < 7; i++) do_step(1, 1, 0, 0, dn);
    do_step(2, 1, 0, 0, dn);
    for (int i = 0; i < 7; i++) do_step(3, 1, 0, 0, dn);
    do_step(2, 1, 0, 0, dn);  // grow at full length is discarded
    do_step(2, 0, 0, 0, dn);  // shorter scan shows grow_pending cleared
    checks++;
    if (length !== 8'(TMAX)) begin
      failures++;
      $display("FAIL max_length got %0d want %0d", length, TMAX);
    end
  endtask

  task automatic test_random();
    bit dn;
    for (int ep = 0; ep < 6; ep++) begin
      do_restart();
      dn = 1'b0;
      for (int s = 0; s < 40 && !dn; s++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_step(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 1'b1,
                ($urandom_range(0, 3) == 0), dn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_grow_reversal();
    test_wall();
    test_self_collision();
    test_tail_follow();
    test_restart_mid_scan();
    test_max_length();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
